// File: rtl/pipeline_pkg.sv
// Shared types and constants for the five-stage pipeline stall/flush controller.
package pipeline_pkg;

    localparam int DEFAULT_REG_W = 5;
    localparam int CNT_W         = 3;

    // 2'd3 is unused and steers back to RUN in the controller.
    typedef enum logic [1:0] {
        RUN    = 2'd0,
        MULDIV = 2'd1,
        DWAIT  = 2'd2
    } ctrl_state_e;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard comparator: a load in EX feeding a source register of the ID instruction.
module load_use_detect #(
    parameter int REG_W = 5
) (
    input  logic             ex_memread_i,
    input  logic [REG_W-1:0] ex_rt_i,
    input  logic [REG_W-1:0] id_rs_i,
    input  logic [REG_W-1:0] id_rt_i,
    input  logic             id_uses_rt_i,
    output logic             hazard_o
);

    logic rsMatch;
    logic rtMatch;
    logic destNonZero;

    // Register 0 is hard-wired, so a load targeting it can never create a dependency.
    always_comb begin
        destNonZero = (ex_rt_i != '0);
        rsMatch     = (ex_rt_i == id_rs_i);
        rtMatch     = id_uses_rt_i & (ex_rt_i == id_rt_i);
        hazard_o    = ex_memread_i & destNonZero & (rsMatch | rtMatch);
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/flush controller driving the PC and all pipeline-register enables and clears.
module pipeline_ctrl
    import pipeline_pkg::*;
#(
    parameter int REG_W      = DEFAULT_REG_W,
    parameter int MUL_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_memread,
    input  logic [REG_W-1:0] ex_rt,
    input  logic             ex_branch_taken,
    input  logic             ex_muldiv_start,
    input  logic             imem_ready,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_we,
    output logic             ifid_we,
    output logic             idex_we,
    output logic             exmem_we,
    output logic             memwb_we,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             memwb_flush,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] muldiv_cnt
);

    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam bit               MUL_MULTI = (MUL_CYCLES > 1);

    ctrl_state_e      state_q, state_d;
    logic [CNT_W-1:0] muldivCnt_q, muldivCnt_d;
    logic             loadUse;
    logic             dataWait;
    logic             inMuldiv;

    load_use_detect #(
        .REG_W(REG_W)
    ) u_load_use_detect (
        .ex_memread_i (ex_memread),
        .ex_rt_i      (ex_rt),
        .id_rs_i      (id_rs),
        .id_rt_i      (id_rt),
        .id_uses_rt_i (id_uses_rt),
        .hazard_o     (loadUse)
    );

    // MEM only holds bubbles during a mult/div, so a data-memory request is ignored there.
    always_comb begin
        inMuldiv = (state_q == MULDIV);
        dataWait = dmem_req & ~dmem_ready & ~inMuldiv;
    end

    // State and mult/div counter registers; reset aborts any wait straight back to RUN.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= RUN;
            muldivCnt_q <= '0;
        end else begin
            state_q     <= state_d;
            muldivCnt_q <= muldivCnt_d;
        end
    end

    // Next state: DWAIT and the illegal code both follow RUN rules, so only MULDIV is special.
    always_comb begin
        state_d     = RUN;
        muldivCnt_d = '0;
        case (state_q)
            MULDIV: begin
                if (muldivCnt_q <= CNT_W'(1)) begin
                    state_d     = RUN;
                    muldivCnt_d = '0;
                end else begin
                    state_d     = MULDIV;
                    muldivCnt_d = muldivCnt_q - CNT_W'(1);
                end
            end
            default: begin
                if (dataWait) begin
                    state_d = DWAIT;
                end else if (ex_muldiv_start && MUL_MULTI) begin
                    state_d     = MULDIV;
                    muldivCnt_d = MUL_LOAD;
                end
            end
        endcase
    end

    // Outputs in priority order: reset, mult/div occupancy, data wait, mult/div start, branch, load-use, fetch miss.
    always_comb begin
        pc_we       = 1'b1;
        ifid_we     = 1'b1;
        idex_we     = 1'b1;
        exmem_we    = 1'b1;
        memwb_we    = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        memwb_flush = 1'b0;
        if (!reset) begin
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            idex_we     = 1'b0;
            exmem_we    = 1'b0;
            memwb_we    = 1'b0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            memwb_flush = 1'b1;
        end else if (inMuldiv || dataWait == 1'b0 && ex_muldiv_start) begin
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            idex_we     = 1'b0;
            exmem_flush = 1'b1;
        end else if (dataWait) begin
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            idex_we     = 1'b0;
            exmem_we    = 1'b0;
            memwb_flush = 1'b1;
        end else if (ex_branch_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (loadUse) begin
            pc_we      = 1'b0;
            ifid_we    = 1'b0;
            idex_flush = 1'b1;
        end else if (!imem_ready) begin
            pc_we      = 1'b0;
            ifid_flush = 1'b1;
        end
    end

    // Observability of the controller's internal state.
    always_comb begin
        state      = state_q;
        muldiv_cnt = muldivCnt_q;
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed self-checking bench for pipeline_ctrl with MUL_CYCLES = 4.
module tb_pipeline_ctrl;

    logic       clk;
    logic       reset;
    logic [4:0] id_rs, id_rt, ex_rt;
    logic       id_uses_rt, ex_memread, ex_branch_taken, ex_muldiv_start;
    logic       imem_ready, dmem_req, dmem_ready;
    logic       pc_we, ifid_we, idex_we, exmem_we, memwb_we;
    logic       ifid_flush, idex_flush, exmem_flush, memwb_flush;
    logic [1:0] state;
    logic [2:0] muldiv_cnt;

    int testCount = 0;
    int failCount = 0;

    pipeline_ctrl #(
        .REG_W(5),
        .MUL_CYCLES(4)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_uses_rt      (id_uses_rt),
        .ex_memread      (ex_memread),
        .ex_rt           (ex_rt),
        .ex_branch_taken (ex_branch_taken),
        .ex_muldiv_start (ex_muldiv_start),
        .imem_ready      (imem_ready),
        .dmem_req        (dmem_req),
        .dmem_ready      (dmem_ready),
        .pc_we           (pc_we),
        .ifid_we         (ifid_we),
        .idex_we         (idex_we),
        .exmem_we        (exmem_we),
        .memwb_we        (memwb_we),
        .ifid_flush      (ifid_flush),
        .idex_flush      (idex_flush),
        .exmem_flush     (exmem_flush),
        .memwb_flush     (memwb_flush),
        .state           (state),
        .muldiv_cnt      (muldiv_cnt)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one cycle's inputs on the falling edge and let the combinational outputs settle.
    task automatic applyStimulus(input logic memread, input logic [4:0] exRt,
                                 input logic [4:0] idRs, input logic [4:0] idRt,
                                 input logic usesRt, input logic branch,
                                 input logic mdStart, input logic imemRdy,
                                 input logic dReq, input logic dRdy);
        @(negedge clk);
        ex_memread      = memread;
        ex_rt           = exRt;
        id_rs           = idRs;
        id_rt           = idRt;
        id_uses_rt      = usesRt;
        ex_branch_taken = branch;
        ex_muldiv_start = mdStart;
        imem_ready      = imemRdy;
        dmem_req        = dReq;
        dmem_ready      = dRdy;
        #1;
    endtask

    // Compare enables {pc,ifid,idex,exmem,memwb}, clears {ifid,idex,exmem,memwb}, state and counter.
    task automatic checkOutput(input string tag, input logic [4:0] expWe,
                               input logic [3:0] expFlush, input logic [1:0] expState,
                               input logic [2:0] expCnt);
        logic [4:0] obsWe;
        logic [3:0] obsFlush;
        obsWe    = {pc_we, ifid_we, idex_we, exmem_we, memwb_we};
        obsFlush = {ifid_flush, idex_flush, exmem_flush, memwb_flush};
        testCount++;
        assert (obsWe === expWe) else begin
            failCount++;
            $error("[TB] FAIL %s we: got %b expected %b", tag, obsWe, expWe);
        end
        testCount++;
        assert (obsFlush === expFlush) else begin
            failCount++;
            $error("[TB] FAIL %s flush: got %b expected %b", tag, obsFlush, expFlush);
        end
        testCount++;
        assert (state === expState) else begin
            failCount++;
            $error("[TB] FAIL %s state: got %0d expected %0d", tag, state, expState);
        end
        testCount++;
        assert (muldiv_cnt === expCnt) else begin
            failCount++;
            $error("[TB] FAIL %s cnt: got %0d expected %0d", tag, muldiv_cnt, expCnt);
        end
    endtask

    // Linear sequence of directed steps with hand-computed expectations.
    initial begin
        reset = 1'b0;
        ex_memread = 0; ex_rt = 0; id_rs = 0; id_rt = 0; id_uses_rt = 0;
        ex_branch_taken = 0; ex_muldiv_start = 0; imem_ready = 1;
        dmem_req = 0; dmem_ready = 0;

        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        checkOutput("reset0", 5'b00000, 4'b1111, 2'd0, 3'd0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        checkOutput("reset1", 5'b00000, 4'b1111, 2'd0, 3'd0);
        reset = 1'b1;
        #1;
        checkOutput("release", 5'b11111, 4'b0000, 2'd0, 3'd0);

        applyStimulus(1, 5, 5, 0, 0, 0, 0, 1, 0, 0);
        checkOutput("loaduse_rs", 5'b00111, 4'b0100, 2'd0, 3'd0);
        applyStimulus(0, 5, 5, 0, 0, 0, 0, 1, 0, 0);
        checkOutput("after_loaduse", 5'b11111, 4'b0000, 2'd0, 3'd0);
        applyStimulus(1, 5, 3, 5, 1, 0, 0, 1, 0, 0);
        checkOutput("loaduse_rt", 5'b00111, 4'b0100, 2'd0, 3'd0);
        applyStimulus(1, 5, 3, 5, 0, 0, 0, 1, 0, 0);
        checkOutput("rt_unused", 5'b11111, 4'b0000, 2'd0, 3'd0);
        applyStimulus(1, 0, 0, 0, 1, 0, 0, 1, 0, 0);
        checkOutput("reg0_nohaz", 5'b11111, 4'b0000, 2'd0, 3'd0);

        applyStimulus(1, 5, 5, 0, 0, 1, 0, 1, 0, 0);
        checkOutput("branch_lu", 5'b11111, 4'b1100, 2'd0, 3'd0);
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        checkOutput("branch_fmiss", 5'b11111, 4'b1100, 2'd0, 3'd0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("fetch_miss", 5'b01111, 4'b1000, 2'd0, 3'd0);
        applyStimulus(1, 7, 7, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("fmiss_lu", 5'b00111, 4'b0100, 2'd0, 3'd0);

        applyStimulus(0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
        checkOutput("md_start", 5'b00011, 4'b0010, 2'd0, 3'd0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
        checkOutput("md_cnt3", 5'b00011, 4'b0010, 2'd1, 3'd3);
        applyStimulus(0, 0, 0, 0, 0, 1, 1, 1, 1, 0);
        checkOutput("md_cnt2_ign", 5'b00011, 4'b0010, 2'd1, 3'd2);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
        checkOutput("md_cnt1", 5'b00011, 4'b0010, 2'd1, 3'd1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        checkOutput("md_done", 5'b11111, 4'b0000, 2'd0, 3'd0);

        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        checkOutput("dwait1", 5'b00001, 4'b0001, 2'd0, 3'd0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        checkOutput("dwait2", 5'b00001, 4'b0001, 2'd2, 3'd0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        checkOutput("dwait3", 5'b00001, 4'b0001, 2'd2, 3'd0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 1, 1);
        checkOutput("dready", 5'b11111, 4'b0000, 2'd2, 3'd0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        checkOutput("dwait_done", 5'b11111, 4'b0000, 2'd0, 3'd0);

        applyStimulus(0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
        checkOutput("md2_start", 5'b00011, 4'b0010, 2'd0, 3'd0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
        checkOutput("md2_cnt3", 5'b00011, 4'b0010, 2'd1, 3'd3);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
        checkOutput("md2_cnt2", 5'b00011, 4'b0010, 2'd1, 3'd2);
        #1;
        reset = 1'b0;
        #1;
        checkOutput("async_reset", 5'b00000, 4'b1111, 2'd0, 3'd0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        reset = 1'b1;
        #1;
        checkOutput("post_reset", 5'b11111, 4'b0000, 2'd0, 3'd0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        checkOutput("post_reset_run", 5'b11111, 4'b0000, 2'd0, 3'd0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central stall/flush controller for the five-stage MIPS pipeline. It drives the write-enable and clear inputs of the PC register and of the IF/ID, ID/EX, EX/MEM and MEM/WB `fflop` pipeline registers. It resolves load-use hazards, taken branches, instruction-fetch misses, data-memory waits and multi-cycle mult/div occupancy. It is the only block allowed to drive those enables.

## Interface
Parameters:
- `REG_W`, 5, register-address width.
- `MUL_CYCLES`, 4, total EX occupancy of a mult/div (≥1).

Ports:
- `clk` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-low (0 = reset).
- `id_rs`, `id_rt` in REG_W: source registers of the instruction in ID.
- `id_uses_rt` in 1: ID instruction reads rt.
- `ex_memread` in 1: EX instruction is a load.
- `ex_rt` in REG_W: load destination in EX.
- `ex_branch_taken` in 1: branch/jump in EX resolved taken.
- `ex_muldiv_start` in 1: EX holds a mult/div.
- `imem_ready` in 1: fetch data valid this cycle.
- `dmem_req` in 1: MEM instruction accesses data memory.
- `dmem_ready` in 1: data memory completes this cycle.
- `pc_we`, `ifid_we`, `idex_we`, `exmem_we`, `memwb_we` out 1: register enables.
- `ifid_flush`, `idex_flush`, `exmem_flush`, `memwb_flush` out 1: register clears (insert bubble).
- `state` out 2: current FSM state.
- `muldiv_cnt` out 3: remaining mult/div cycles.

## Operation
- FSM states: RUN, MULDIV, DWAIT.
- Default in RUN: all `*_we`=1, all `*_flush`=0.
- Conditions are evaluated in priority order; the first match decides the outputs.
- **1. Data wait** (`dmem_req & !dmem_ready`, in RUN or DWAIT):
  - pc/ifid/idex/exmem `we`=0; `memwb_flush`=1.
  - Next state DWAIT.
  - In DWAIT, the cycle `dmem_ready`=1 is evaluated as RUN, and the next state follows RUN rules.
- **2. Mult/div**:
  - In RUN, `ex_muldiv_start` stalls pc/ifid/idex (`we`=0) and sets `exmem_flush`=1.
  - If `MUL_CYCLES`>1: load `muldiv_cnt`=MUL_CYCLES-1 and go to MULDIV.
  - MULDIV keeps the same stall outputs and decrements the counter each cycle; at `muldiv_cnt`=1 the next state is RUN.
  - Total stall = `MUL_CYCLES` cycles. The result is captured by EX/MEM in the first RUN cycle.
  - `ex_muldiv_start` is ignored outside RUN, since it stays high while EX is held.
  - `dmem_req` is ignored in MULDIV, because MEM holds bubbles.
- **3. Taken branch**:
  - `ifid_flush`=1, `idex_flush`=1, `pc_we`=1.
  - Overrides load-use and fetch-miss.
- **4. Load-use**:
  - Condition: `ex_memread & ex_rt!=0 & (ex_rt==id_rs | (id_uses_rt & ex_rt==id_rt))`.
  - `pc_we`=0, `ifid_we`=0, `idex_flush`=1.
  - One cycle only; no state change.
- **5. Fetch miss** (`!imem_ready`):
  - `pc_we`=0, `ifid_flush`=1; downstream stages keep running.
  - If load-use holds at the same time: `ifid_we`=0 and `ifid_flush`=0, so the hold wins.
- Register 0 never creates a hazard.

## Timing
- Outputs are combinational from the registered state/counter and the current inputs, with no added latency. Pipeline registers update at the next rising edge.
- While `reset`=0 (asynchronous):
  - `state`=RUN, `muldiv_cnt`=0.
  - All `*_we`=0, all `*_flush`=1.
- Deassertion is synchronised externally. The first edge after deassertion evaluates as RUN.
- Reset mid-MULDIV or mid-DWAIT aborts immediately to RUN with the counter at 0.
- Counter arithmetic is unsigned 3-bit. `MUL_CYCLES` ≤ 8; the counter never wraps.

## Structure
- `pipeline_pkg` holds:
  - State encoding: RUN=2'd0, MULDIV=2'd1, DWAIT=2'd2; 2'd3 is illegal and recovers to RUN.
  - `REG_W` default.
  - `CNT_W`=3.
- Sub-module `load_use_detect`: the combinational comparator in rule 4. The remaining logic stays in `pipeline_ctrl`.

## Test plan
- **Reset:** hold `reset`=0 for 2 cycles, then release → during reset all we=0, flush=1, state=0; after release, the first cycle shows all we=1, flush=0.
- **Load-use:** `ex_memread`=1, `ex_rt`=5, `id_rs`=5 → one cycle of `pc_we`=0, `ifid_we`=0, `idex_flush`=1. Repeat with `ex_rt`=0 → no stall.
- **Branch during load-use:** same hazard plus `ex_branch_taken`=1 → `pc_we`=1, `ifid_flush`=1, `idex_flush`=1.
- **Mult/div (`MUL_CYCLES`=4):** assert start in RUN and hold it → exactly 4 stall cycles; `muldiv_cnt` reads 3,2,1 in MULDIV; state returns to 0 on the 5th cycle with `exmem_we`=1.
- **Data wait:** `dmem_req`=1, `dmem_ready`=0 for 3 cycles, then 1 → 3 cycles of frozen pc..exmem with `memwb_flush`=1 and state=2; normal outputs in the ready cycle.
- **Reset mid-operation:** drop `reset` during the 2nd MULDIV cycle → state=0 and cnt=0 immediately, without waiting for an edge.
